// File: rtl/m_store_buffer_pkg.sv
// Shared types for the M-stage store buffer: DM access codes, word-index slice, entry layout.
package m_store_buffer_pkg;

  localparam int unsigned SbAw      = 32;
  localparam int unsigned WordIdxHi = 13;
  localparam int unsigned WordIdxLo = 2;
  localparam int unsigned WidxW     = WordIdxHi - WordIdxLo + 1;

  typedef enum logic [2:0] {
    DmWord  = 3'd0,
    DmHalf  = 3'd1,
    DmByte  = 3'd2,
    DmHalfU = 3'd3,
    DmByteU = 3'd4,
    DmSwl   = 3'd5,
    DmSwr   = 3'd6
  } dm_type_e;

  typedef struct packed {
    logic            valid;
    dm_type_e        dtype;
    logic [SbAw-1:0] addr;
    logic [SbAw-1:0] data;
    logic [SbAw-1:0] pc;
  } sb_entry_t;

endpackage

// File: rtl/m_store_buffer_sb_match.sv
// Parallel word-index compare of a load against all buffered stores.
// With SB_LDFWD_EN defined it also selects the youngest hit for load forwarding.
module m_store_buffer_sb_match
  import m_store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
`ifdef SB_LDFWD_EN
  input  dm_type_e [DEPTH-1:0]            dtype,
  input  logic     [DEPTH-1:0][SbAw-1:0]  data,
  input  logic     [$clog2(DEPTH)-1:0]    wr_ptr,
  output logic                            fwd_valid,
  output logic     [SbAw-1:0]             fwd_data,
`endif
  input  logic     [DEPTH-1:0]            valid,
  input  logic     [DEPTH-1:0][WidxW-1:0] widx,
  input  logic                            ld_req,
  input  logic     [WidxW-1:0]            ld_widx,
  output logic     [DEPTH-1:0]            hit_vec,
  output logic                            ld_hit
);

  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      hit_vec[i] = ld_req && valid[i] && (widx[i] == ld_widx);
    end
  end

  assign ld_hit = |hit_vec;

`ifdef SB_LDFWD_EN
  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW-1:0] idx;
  logic            found;

  // Walk backwards from wr_ptr so the first hit seen is the youngest store.
  always_comb begin
    fwd_valid = 1'b0;
    fwd_data  = '0;
    found     = 1'b0;
    idx       = '0;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      idx = wr_ptr - PtrW'(k);
      if (!found && hit_vec[idx]) begin
        found     = 1'b1;
        fwd_valid = (dtype[idx] == DmWord);
        fwd_data  = data[idx];
      end
    end
  end
`endif

endmodule

// File: rtl/m_store_buffer.sv
// Store buffer between the M-stage register and the DM write port; drains one store per
// free port cycle and stalls loads that hit a pending word. SB_LDFWD_EN adds word forwarding.
module m_store_buffer
  import m_store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          st_valid,
  output logic          st_ready,
  input  logic [AW-1:0] st_addr,
  input  logic [AW-1:0] st_data,
  input  logic [2:0]    st_type,
  input  logic [AW-1:0] st_pc,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_stall,
`ifdef SB_LDFWD_EN
  output logic          ld_fwd_valid,
  output logic [AW-1:0] ld_fwd_data,
`endif
  output logic          dm_we,
  output logic [AW-1:0] dm_A,
  output logic [AW-1:0] dm_WD,
  output logic [2:0]    dm_DMType,
  output logic [AW-1:0] dm_PC,
  output logic          sb_empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  sb_entry_t [DEPTH-1:0] entries_q;
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q, count_d;

  logic full, empty, push, pop, ld_hit;
  logic [DEPTH-1:0]            hit_vec;
  logic [DEPTH-1:0]            valid_vec;
  logic [DEPTH-1:0][WidxW-1:0] widx_vec;
  logic                        unused_ld_addr;

  assign full     = (count_q == CntW'(DEPTH));
  assign empty    = (count_q == '0);
  assign st_ready = !full;
  assign sb_empty = empty;
  assign push     = st_valid && !full;
  assign pop      = dm_we;

  // A load that misses owns the DM port; a stalled load yields it so the hit can drain.
  assign dm_we     = !empty && (!ld_req || ld_hit);
  assign dm_A      = AW'(entries_q[rd_ptr_q].addr);
  assign dm_WD     = AW'(entries_q[rd_ptr_q].data);
  assign dm_DMType = entries_q[rd_ptr_q].dtype;
  assign dm_PC     = AW'(entries_q[rd_ptr_q].pc);

  assign unused_ld_addr = ^{ld_addr[AW-1:WordIdxHi+1], ld_addr[WordIdxLo-1:0]};

  always_comb begin
    valid_vec = '0;
    widx_vec  = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      valid_vec[i] = entries_q[i].valid;
      widx_vec[i]  = entries_q[i].addr[WordIdxHi:WordIdxLo];
    end
  end

`ifdef SB_LDFWD_EN
  dm_type_e [DEPTH-1:0]           dtype_vec;
  logic     [DEPTH-1:0][SbAw-1:0] data_vec;
  logic                           fwd_valid;
  logic     [SbAw-1:0]            fwd_data;

  always_comb begin
    dtype_vec = {DEPTH{DmWord}};
    data_vec  = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      dtype_vec[i] = entries_q[i].dtype;
      data_vec[i]  = entries_q[i].data;
    end
  end

  m_store_buffer_sb_match #(
    .DEPTH (DEPTH)
  ) u_match (
    .dtype     (dtype_vec),
    .data      (data_vec),
    .wr_ptr    (wr_ptr_q),
    .fwd_valid (fwd_valid),
    .fwd_data  (fwd_data),
    .valid     (valid_vec),
    .widx      (widx_vec),
    .ld_req    (ld_req),
    .ld_widx   (ld_addr[WordIdxHi:WordIdxLo]),
    .hit_vec   (hit_vec),
    .ld_hit    (ld_hit)
  );

  assign ld_fwd_valid = fwd_valid;
  assign ld_fwd_data  = AW'(fwd_data);
  assign ld_stall     = ld_hit && !fwd_valid;
`else
  m_store_buffer_sb_match #(
    .DEPTH (DEPTH)
  ) u_match (
    .valid   (valid_vec),
    .widx    (widx_vec),
    .ld_req  (ld_req),
    .ld_widx (ld_addr[WordIdxHi:WordIdxLo]),
    .hit_vec (hit_vec),
    .ld_hit  (ld_hit)
  );

  assign ld_stall = ld_hit;
`endif

  always_comb begin
    count_d = count_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entries_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      if (pop) begin
        entries_q[rd_ptr_q].valid <= 1'b0;
        rd_ptr_q                  <= rd_ptr_q + PtrW'(1);
      end
      if (push) begin
        entries_q[wr_ptr_q] <= '{valid: 1'b1,
                                 dtype: dm_type_e'(st_type),
                                 addr:  SbAw'(st_addr),
                                 data:  SbAw'(st_data),
                                 pc:    SbAw'(st_pc)};
        wr_ptr_q            <= wr_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
    end
  end

endmodule
